// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and clock mode constants,
// used by the pin front-end and the slave shift register.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic CPOL_IDLE_LOW        = 1'b0;
  localparam logic CPOL_IDLE_HIGH       = 1'b1;
  localparam logic CPHA_SAMPLE_LEADING  = 1'b0;
  localparam logic CPHA_SAMPLE_TRAILING = 1'b1;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // True when an edge of the given direction is the data-sample edge for cpha.
  function automatic logic is_sample_edge(input logic leading, input logic cpha);
    return (cpha == CPHA_SAMPLE_LEADING) ? leading : !leading;
  endfunction

endpackage

// File: rtl/spi_sync_filter.sv
// One asynchronous pin: SYNC_STAGES-deep synchroniser followed by a glitch
// filter that only follows a level held for FILTER_LEN consecutive cycles.
module spi_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [2:0] CNT_LAST = 3'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    // The counter only runs while the synchronised level disagrees with the
    // output; any agreeing cycle restarts the qualification window.
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= '0;
      filt_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/spi_edge_sync.sv
// SPI slave front-end: synchronises and filters sck/cs/mosi, tracks frames and
// produces registered sample/shift strobes, bit index and frame event pulses.
module spi_edge_sync
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MAX_WIDTH_LOG = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned FILTER_LEN        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width,
  input  logic                         sck,
  input  logic                         cs,
  input  logic                         mosi,
  output logic                         mosi_s,
  output logic                         sample_stb,
  output logic                         shift_stb,
  output logic [SPI_MAX_WIDTH_LOG-1:0] bit_cnt,
  output logic                         frame_start,
  output logic                         word_done,
  output logic                         frame_end,
  output logic                         frame_abort,
  output logic                         busy
);

  localparam logic [SPI_MAX_WIDTH_LOG-1:0] BIT_ONE = SPI_MAX_WIDTH_LOG'(1);

  logic cs_f, sck_f, mosi_f;

  spi_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b1)
  ) u_cs_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs),
    .dout (cs_f)
  );

  spi_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b0)
  ) u_sck_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sck),
    .dout (sck_f)
  );

  spi_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b0)
  ) u_mosi_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (mosi),
    .dout (mosi_f)
  );

  spi_state_e                   state_q, state_d;
  spi_mode_t                    mode_q, mode_d;
  logic [SPI_MAX_WIDTH_LOG-1:0] width_q, width_d;
  logic [SPI_MAX_WIDTH_LOG-1:0] bit_cnt_q, bit_cnt_d;
  logic                         cs_prev_q, cs_prev_d;
  logic                         sck_ref_q, sck_ref_d;
  logic                         mosi_s_q, mosi_s_d;
  logic                         sample_q, sample_d;
  logic                         shift_q, shift_d;
  logic                         start_q, start_d;
  logic                         done_q, done_d;
  logic                         end_q, end_d;
  logic                         abort_q, abort_d;

  logic cs_fall, cs_rise, sck_lvl;

  assign cs_fall = cs_prev_q & ~cs_f;
  assign cs_rise = ~cs_prev_q & cs_f;
  assign sck_lvl = sck_f ^ mode_q.cpol;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    width_d   = width_q;
    bit_cnt_d = bit_cnt_q;
    sck_ref_d = sck_ref_q;
    cs_prev_d = cs_f;
    mosi_s_d  = mosi_f;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    end_d     = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_ACTIVE;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          width_d     = spi_width;
          bit_cnt_d   = '0;
          sck_ref_d   = sck_f ^ cpol;
          start_d     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // cs release takes priority so a coincident sck edge never strobes.
        if (cs_rise) begin
          state_d   = ST_IDLE;
          end_d     = 1'b1;
          abort_d   = (bit_cnt_q != '0);
          bit_cnt_d = '0;
        end else if (sck_lvl != sck_ref_q) begin
          sck_ref_d = sck_lvl;
          if (is_sample_edge(sck_lvl, mode_q.cpha)) begin
            sample_d = 1'b1;
            if (bit_cnt_q == width_q) begin
              done_d    = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
          end else begin
            shift_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= '{cpol: CPOL_IDLE_LOW, cpha: CPHA_SAMPLE_LEADING};
      width_q   <= '0;
      bit_cnt_q <= '0;
      cs_prev_q <= 1'b1;
      sck_ref_q <= 1'b0;
      mosi_s_q  <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      end_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      width_q   <= width_d;
      bit_cnt_q <= bit_cnt_d;
      cs_prev_q <= cs_prev_d;
      sck_ref_q <= sck_ref_d;
      mosi_s_q  <= mosi_s_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      start_q   <= start_d;
      done_q    <= done_d;
      end_q     <= end_d;
      abort_q   <= abort_d;
    end
  end

  assign mosi_s      = mosi_s_q;
  assign sample_stb  = sample_q;
  assign shift_stb   = shift_q;
  assign bit_cnt     = bit_cnt_q;
  assign frame_start = start_q;
  assign word_done   = done_q;
  assign frame_end   = end_q;
  assign frame_abort = abort_q;
  assign busy        = (state_q == ST_ACTIVE);

endmodule

// File: doc/spi_edge_sync.md
SPI_EDGE_SYNC -- requirements
Module: spi_edge_sync

Interface
REQ-001 Parameter SPI_MAX_WIDTH_LOG, default 4, log2 of the maximum word length (word length 1..2^SPI_MAX_WIDTH_LOG bits).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops per pin input, legal range 2..4.
REQ-003 Parameter FILTER_LEN, default 2, number of consecutive stable clk cycles required before a synchronised level is accepted, legal range 1..8.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cpol  input  1  SPI clock polarity; read only at frame start.
REQ-007 cpha  input  1  SPI clock phase; read only at frame start.
REQ-008 spi_width  input  SPI_MAX_WIDTH_LOG  word length minus 1; read only at frame start.
REQ-009 sck, cs, mosi  input  1 each  asynchronous SPI pins; cs active-low.
REQ-010 mosi_s  output  1  filtered mosi, aligned so it is valid in the cycle sample_stb is high.
REQ-011 sample_stb, shift_stb  output  1 each  one-cycle data sample / data shift strobes.
REQ-012 bit_cnt  output  SPI_MAX_WIDTH_LOG  index of the next bit to be sampled within the current word.
REQ-013 frame_start, word_done, frame_end, frame_abort  output  1 each  one-cycle event pulses.
REQ-014 busy  output  1  high while in state ACTIVE.

Function
REQ-015 Each pin passes through a SYNC_STAGES flop chain, then a filter that updates its output only after the synchronised level differs from it for FILTER_LEN consecutive cycles; any shorter pulse is discarded.
REQ-016 All outputs are registered; an event asserts exactly LAT = SYNC_STAGES + FILTER_LEN cycles after the clk edge that first samples a stable pin change.
REQ-017 State machine has two states, IDLE and ACTIVE; IDLE -> ACTIVE on a filtered cs falling edge; ACTIVE -> IDLE on a filtered cs rising edge.
REQ-018 On IDLE -> ACTIVE: frame_start pulses, cpol/cpha/spi_width are latched, bit_cnt clears to 0, and the sck edge reference loads the current filtered sck XOR latched cpol.
REQ-019 In the cycle cs falls, any sck edge is ignored; sck edges are ignored throughout IDLE.
REQ-020 Leading edge = 0->1 transition of (filtered sck XOR latched cpol); trailing edge = 1->0 transition.
REQ-021 cpha=0: sample_stb on leading edge, shift_stb on trailing edge; cpha=1: shift_stb on leading edge, sample_stb on trailing edge.
REQ-022 Each sample_stb increments bit_cnt; when sample_stb occurs with bit_cnt == latched spi_width, word_done pulses in the same cycle and bit_cnt wraps to 0 (back-to-back words within one frame).
REQ-023 On ACTIVE -> IDLE: frame_end pulses; frame_abort pulses in the same cycle if bit_cnt != 0; bit_cnt clears to 0.
REQ-024 A sck edge coincident with the cs rising edge is ignored (no strobe, no count change).
REQ-025 spi_width = 0 gives one-bit words: word_done on every sample_stb, bit_cnt stays 0.
REQ-026 Changes to cpol/cpha/spi_width while ACTIVE have no effect until the next frame.

Reset
REQ-027 While rst_n is low: cs chain and filter hold 1, sck and mosi chains and filters hold 0, state IDLE, latched mode 0, bit_cnt 0.
REQ-028 While rst_n is low: all outputs 0 (busy 0, all strobes and pulses 0, mosi_s 0).
REQ-029 Reset asserted mid-frame abandons the frame without frame_end or frame_abort; after release a frame starts only on a fresh cs falling edge.

Structure
REQ-030 Package spi_pkg holds the IDLE/ACTIVE state encoding and the cpol/cpha mode constants, shared with the SPI slave shift register.
REQ-031 Sub-module spi_sync_filter (parameters SYNC_STAGES, FILTER_LEN, RESET_VAL) implements one pin's synchroniser and filter; instantiated three times.

Verification
REQ-032 Mode 0, spi_width=7, cs low, 8 sck pulses of 8 clk high/8 low, mosi=0xA5 -> 8 sample_stb, mosi_s at strobes 1,0,1,0,0,1,0,1, one word_done on the 8th, frame_end, no frame_abort.
REQ-033 Modes 1, 2 and 3, same frame -> sample_stb on the edge set by REQ-021, each exactly LAT=4 cycles after the sampled pin edge.
REQ-034 spi_width=3, 16 sck pulses in one frame -> 4 word_done pulses, bit_cnt sequence 0..3 repeated.
REQ-035 spi_width=7, cs rises after 5 samples -> frame_end and frame_abort in the same cycle, bit_cnt 0.
REQ-036 1-clk glitch on sck during ACTIVE with FILTER_LEN=2 -> no strobes, bit_cnt unchanged.
REQ-037 rst_n low mid-word after 3 samples -> all outputs 0 immediately; after release no events until the next cs falling edge.
